// File: rtl/fifo2core_weight_unpack.sv
// Weight-path unpacker: pops packed words from the weight FIFO and streams
// them LSB-lane first to the core as W_BW-bit weights over valid/ready.
module fifo2core_weight_unpack #(
  parameter int unsigned MEM_SIZE = 40,
  parameter int unsigned W_BW     = 8,
  parameter int unsigned N_C1     = 2,
  parameter int unsigned N_C3     = 4,
  parameter int unsigned N_C5     = 24,
  parameter int unsigned N_FC     = 17,
  parameter int unsigned N_OL     = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          layer_signal,
  input  logic [MEM_SIZE-1:0] fifo_din,
  input  logic                fifo_empty,
  output logic                fifo_re,
  output logic [W_BW-1:0]     w_data,
  output logic                w_valid,
  input  logic                w_ready,
  output logic                w_last,
  output logic                layer_done,
  output logic                busy
);

  localparam int unsigned LANES  = MEM_SIZE / W_BW;
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned CNT_W  = 6;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  localparam logic [2:0] LS_C1 = 3'd1;
  localparam logic [2:0] LS_C3 = 3'd3;
  localparam logic [2:0] LS_C5 = 3'd5;
  localparam logic [2:0] LS_FC = 3'd6;
  localparam logic [2:0] LS_OL = 3'd7;

  if ((MEM_SIZE % W_BW) != 0) begin : g_bad_width
    $error("MEM_SIZE must be an exact multiple of W_BW");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          layer_q, layer_d;
  logic [CNT_W-1:0]    target_q, target_d;
  logic [CNT_W-1:0]    word_q, word_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [MEM_SIZE-1:0] sreg_q, sreg_d;
  logic                w_valid_q, w_last_q, done_q, busy_q;
  logic                start_c;
  logic [CNT_W-1:0]    tgt_c;

  // Decode which layer codes start a stream and their word counts
  always_comb begin
    start_c = 1'b1;
    tgt_c   = '0;
    case (layer_signal)
      LS_C1:   tgt_c = CNT_W'(N_C1);
      LS_C3:   tgt_c = CNT_W'(N_C3);
      LS_C5:   tgt_c = CNT_W'(N_C5);
      LS_FC:   tgt_c = CNT_W'(N_FC);
      LS_OL:   tgt_c = CNT_W'(N_OL);
      default: start_c = 1'b0;
    endcase
  end

  // Next-state, counter and FIFO read logic
  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    target_d = target_q;
    word_d   = word_q;
    lane_d   = lane_q;
    sreg_d   = sreg_q;
    fifo_re  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_c) begin
          layer_d  = layer_signal;
          target_d = tgt_c;
          word_d   = '0;
          lane_d   = '0;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        fifo_re = !fifo_empty;
        if (!fifo_empty) state_d = S_LOAD;
      end
      S_LOAD: begin
        sreg_d  = fifo_din;
        lane_d  = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_ready) begin
          sreg_d = sreg_q >> W_BW;
          if (lane_q == LAST_LANE) begin
            lane_d  = '0;
            word_d  = word_q + CNT_W'(1);
            state_d = (word_q == target_q - CNT_W'(1)) ? S_DONE : S_FETCH;
          end else begin
            lane_d = lane_q + LANE_W'(1);
          end
        end
      end
      S_DONE: begin
        // Hold here while the same layer code persists so it is not re-run
        if (layer_signal != layer_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      layer_q   <= '0;
      target_q  <= '0;
      word_q    <= '0;
      lane_q    <= '0;
      sreg_q    <= '0;
      w_valid_q <= 1'b0;
      w_last_q  <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      layer_q   <= layer_d;
      target_q  <= target_d;
      word_q    <= word_d;
      lane_q    <= lane_d;
      sreg_q    <= sreg_d;
      w_valid_q <= (state_d == S_SHIFT);
      w_last_q  <= (state_d == S_SHIFT) && (lane_d == LAST_LANE) &&
                   (word_d == target_d - CNT_W'(1));
      done_q    <= (state_d == S_DONE) && (state_q != S_DONE);
      busy_q    <= (state_d != S_IDLE);
    end
  end

  assign w_data     = sreg_q[W_BW-1:0];
  assign w_valid    = w_valid_q;
  assign w_last     = w_last_q;
  assign layer_done = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fifo2core_weight_unpack.sv
// Scoreboard bench for the weight unpacker: FIFO model, expected-weight
// queue filled at stimulus time, and a negedge monitor that checks beats.
module tb_fifo2core_weight_unpack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  layer_signal = 3'd0;
  logic [39:0] fifo_din = '0;
  logic        fifo_empty;
  logic        fifo_re;
  logic [7:0]  w_data;
  logic        w_valid;
  logic        w_ready = 1'b0;
  logic        w_last;
  logic        layer_done;
  logic        busy;

  fifo2core_weight_unpack dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .layer_signal (layer_signal),
    .fifo_din     (fifo_din),
    .fifo_empty   (fifo_empty),
    .fifo_re      (fifo_re),
    .w_data       (w_data),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .w_last       (w_last),
    .layer_done   (layer_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t        exp_q[$];
  logic [39:0] fq[$];
  int fq_pushes = 0, fq_pops = 0, rd_cnt = 0;
  int done_cnt = 0, beats_seen = 0;
  int errors = 0, checks = 0;
  logic hold_empty = 1'b0;
  logic re_s = 1'b0;
  int rdy_mode = 0;
  int pat_i = 0;
  logic [3:0] pat = 4'b1001;

  assign fifo_empty = hold_empty || (fq_pushes == fq_pops);

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each 40-bit word yields five bytes, least significant first
  task automatic push_word(input logic [39:0] w, input bit last_word);
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      e.d = w[8*i +: 8];
      e.l = last_word && (i == 4);
      exp_q.push_back(e);
    end
    fq.push_back(w);
    fq_pushes++;
  endtask

  task automatic push_layer(input int n);
    logic [63:0] r;
    for (int i = 0; i < n; i++) begin
      r = {$urandom, $urandom};
      push_word(r[39:0], i == n - 1);
    end
  endtask

  task automatic wait_done(input int nw, input int brd, input int bdone);
    int cyc;
    cyc = 0;
    while (done_cnt == bdone && cyc < 3000) begin
      tick();
      cyc++;
    end
    chk("done_timeout", longint'(cyc < 3000), 1);
    tick();
    tick();
    chk("reads_per_layer", longint'(rd_cnt - brd), longint'(nw));
    chk("done_pulses", longint'(done_cnt - bdone), 1);
    chk("scoreboard_drained", longint'(exp_q.size()), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_w_valid"}, w_valid, 0);
    chk({tag, "_w_data"}, w_data, 0);
    chk({tag, "_w_last"}, w_last, 0);
    chk({tag, "_layer_done"}, layer_done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fifo_re"}, fifo_re, 0);
  endtask

  // FIFO model: data appears the cycle after a sampled read enable
  always @(negedge clk) re_s = rst_n && fifo_re;

  always @(posedge clk) begin
    if (re_s) begin
      if (fq.size() == 0) chk("fifo_underflow", 1, 0);
      else fifo_din <= fq.pop_front();
      fq_pops <= fq_pops + 1;
      rd_cnt  <= rd_cnt + 1;
    end
  end

  // Core-side ready generator
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: w_ready = 1'b1;
      1: w_ready = 1'($urandom_range(0, 1));
      default: begin
        w_ready = pat[pat_i];
        pat_i = (pat_i + 1) % 4;
      end
    endcase
  end

  // Monitor: compares every accepted beat against the scoreboard
  logic       prev_stall = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_data = '0;
  exp_t       e_mon;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_last  = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", w_valid, 1);
        chk("hold_data", w_data, prev_data);
      end
      if (layer_done) begin
        done_cnt++;
        chk("done_after_last_beat", prev_last, 1);
      end
      if (fifo_re) chk("read_while_empty", fifo_empty, 0);
      if (w_valid && w_ready) begin
        beats_seen++;
        if (exp_q.size() == 0) chk("spurious_beat", 1, 0);
        else begin
          e_mon = exp_q.pop_front();
          chk("w_data", w_data, e_mon.d);
          chk("w_last", w_last, e_mon.l);
        end
      end
      prev_stall = w_valid && !w_ready;
      prev_data  = w_data;
      prev_last  = w_valid && w_ready && w_last;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int brd, bdone, bb, cyc;
    rdy_mode = 0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // C1 with known words and startup latency
    push_word(40'h0504030201, 1'b0);
    push_word(40'h0A09080706, 1'b1);
    brd = rd_cnt; bdone = done_cnt;
    layer_signal = 3'd1;
    tick();
    chk("c1_fetch_re", fifo_re, 1);
    chk("c1_busy", busy, 1);
    tick();
    chk("c1_load_no_valid", w_valid, 0);
    tick();
    chk("c1_first_valid", w_valid, 1);
    chk("c1_first_data", w_data, 8'h01);
    wait_done(2, brd, bdone);
    layer_signal = 3'd0;
    tick(); tick();
    chk("c1_idle_busy", busy, 0);

    // C3 under 1,0,0,1 backpressure
    push_layer(4);
    rdy_mode = 2;
    bb = beats_seen; brd = rd_cnt; bdone = done_cnt;
    layer_signal = 3'd3;
    wait_done(4, brd, bdone);
    chk("c3_beats", longint'(beats_seen - bb), 20);
    layer_signal = 3'd0;
    rdy_mode = 0;
    tick(); tick();

    // C5 with a 10-cycle empty FIFO after the third word
    push_layer(24);
    bb = beats_seen; brd = rd_cnt; bdone = done_cnt;
    layer_signal = 3'd5;
    cyc = 0;
    while (rd_cnt - brd < 3 && cyc < 500) begin
      tick();
      cyc++;
    end
    hold_empty = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_no_read", fifo_re, 0);
    end
    chk("stall_valid_low", w_valid, 0);
    chk("stall_busy", busy, 1);
    hold_empty = 1'b0;
    wait_done(24, brd, bdone);
    chk("c5_beats", longint'(beats_seen - bb), 120);
    layer_signal = 3'd0;
    tick(); tick();

    // FC with random ready, then hold the code with OL words waiting
    push_layer(17);
    rdy_mode = 1;
    brd = rd_cnt; bdone = done_cnt;
    layer_signal = 3'd6;
    wait_done(17, brd, bdone);
    push_layer(2);
    repeat (20) tick();
    chk("fc_hold_no_reads", longint'(rd_cnt - brd), 17);
    chk("fc_hold_one_done", longint'(done_cnt - bdone), 1);
    chk("fc_hold_busy", busy, 1);
    layer_signal = 3'd0;
    tick(); tick();
    chk("fc_release_idle", busy, 0);

    // Pooling codes must not start anything
    brd = rd_cnt;
    layer_signal = 3'd2;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("s2_busy", busy, 0);
      chk("s2_fifo_re", fifo_re, 0);
    end
    layer_signal = 3'd4;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("s4_busy", busy, 0);
      chk("s4_fifo_re", fifo_re, 0);
    end
    chk("pool_no_reads", longint'(rd_cnt - brd), 0);
    layer_signal = 3'd0;
    tick();

    // OL run from the words preloaded earlier
    bb = beats_seen; bdone = done_cnt;
    layer_signal = 3'd7;
    wait_done(2, brd, bdone);
    chk("ol_beats", longint'(beats_seen - bb), 10);
    layer_signal = 3'd0;
    rdy_mode = 0;
    tick(); tick();

    // Reset mid-C5 after 7 weights, then a fresh C1 run
    push_layer(24);
    bb = beats_seen;
    layer_signal = 3'd5;
    cyc = 0;
    while (beats_seen - bb < 7 && cyc < 500) begin
      tick();
      cyc++;
    end
    chk("rst_reached_7_beats", longint'(cyc < 500), 1);
    #1 rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    layer_signal = 3'd0;
    exp_q.delete();
    fq.delete();
    fq_pushes = fq_pops;
    tick();
    chk_all_zero("midrst_next");
    rst_n = 1'b1;
    tick();
    push_layer(2);
    bb = beats_seen; brd = rd_cnt; bdone = done_cnt;
    layer_signal = 3'd1;
    wait_done(2, brd, bdone);
    chk("post_rst_beats", longint'(beats_seen - bb), 10);
    layer_signal = 3'd0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo2core_weight_unpack.md
# fifo2core_weight_unpack

Weight-path stage between the weight FIFO and the convolution/FC core. It pops packed `MEM_SIZE`-bit words from the FIFO that the BRAM-to-FIFO controller fills. Each word is serialized into `W_BW`-bit weights and handed to the core over a valid/ready handshake. Per-layer word counts delimit each layer's weight stream, with end-of-stream marking and a completion pulse.

## Interface
- `MEM_SIZE`, 40: packed FIFO word width.
- `W_BW`, 8: weight width; `LANES = MEM_SIZE/W_BW` (5); `MEM_SIZE` must be an exact multiple of `W_BW`.
- `N_C1`, 2: words per C1 stream.
- `N_C3`, 4: words per C3 stream.
- `N_C5`, 24: words per C5 stream.
- `N_FC`, 17: words per FC stream.
- `N_OL`, 2: words per OL stream.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; reset rst_n, asynchronous, active-low; clock clk.
- `layer_signal`  in  3  layer code: 0 IDLE, 1 C1, 2 S2, 3 C3, 4 S4, 5 C5, 6 FC, 7 OL.
- `fifo_din`  in  MEM_SIZE  FIFO read data, valid the cycle after `fifo_re`.
- `fifo_empty`  in  1  FIFO empty.
- `fifo_re`  out  1  FIFO read enable, combinational.
- `w_data`  out  W_BW  weight to core, registered.
- `w_valid`  out  1  weight valid.
- `w_ready`  in  1  core accepts weight.
- `w_last`  out  1  marks the final weight of the layer stream.
- `layer_done`  out  1  one-cycle pulse when the stream completes.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- State `IDLE`:
  - When `layer_signal` ∈ {C1, C3, C5, FC, OL}, latch the code, load `target` = matching `N_*`, clear `word_cnt` and `lane_cnt`, go to `FETCH`.
  - IDLE, S2 and S4 codes keep the block in `IDLE`.
- State `FETCH`:
  - `fifo_re` = (state==FETCH) && !`fifo_empty`.
  - If `fifo_re` is high, go to `LOAD`; otherwise wait in `FETCH` indefinitely.
- State `LOAD`: `sreg` <= `fifo_din`, `lane_cnt` <= 0, go to `SHIFT`.
- State `SHIFT`:
  - `w_valid`=1; `w_data` = `sreg[W_BW-1:0]`, so lane 0 (LSBs) goes out first.
  - On a beat (`w_valid`&&`w_ready`): `sreg` shifts right by `W_BW` (zero fill) and `lane_cnt`++.
  - If the beat's `lane_cnt`==LANES-1: `word_cnt`++ and `lane_cnt` <= 0.
    - If `word_cnt`==`target`-1, go to `DONE`.
    - Otherwise go to `FETCH`.
- `w_last` = `SHIFT` && `lane_cnt`==LANES-1 && `word_cnt`==`target`-1.
- State `DONE`:
  - `layer_done` pulses on the single cycle of entry.
  - Stay in `DONE` while `layer_signal` equals the latched code, so the same layer is not re-run; otherwise go to `IDLE`.
- `layer_signal` changes while busy (FETCH/LOAD/SHIFT) are ignored; the latched layer governs until `DONE`.
- With `w_ready` low in `SHIFT`: hold `w_data`/`w_valid` stable, no shift, no FIFO read.
- No FIFO read is issued outside `FETCH`. Exactly `target` reads occur per layer, so no word is over-read.
- Counter widths: `word_cnt` is 6 bits, which covers the maximum `N_*` of 63. `lane_cnt` is clog2(LANES) bits.

## Timing
- Reset values:
  - state `IDLE`.
  - `w_data`=0, `w_valid`=0, `w_last`=0, `layer_done`=0, `busy`=0, `fifo_re`=0.
  - `sreg`=0; all counters 0.
- Reset asserted mid-stream aborts immediately to `IDLE`. Any FIFO word already popped is discarded.
- Startup latency, with FIFO non-empty and `layer_signal` valid at edge 0:
  - `FETCH` and `fifo_re` high in cycle 1.
  - `LOAD` in cycle 2.
  - First `w_valid` in cycle 3.
- Per word: 1 `FETCH` + 1 `LOAD` + LANES beats. Full-rate throughput is LANES weights per LANES+2 cycles.
- `layer_done` rises the cycle after the `w_last` beat is accepted.
- FIFO empty at `FETCH` adds one cycle of stall per empty cycle. `w_valid` stays low during the stall.

## Test plan
- C1, FIFO preloaded with 0x0504030201 and 0x0A09080706, `w_ready`=1:
  - `w_data` sequence 0x01..0x0A; first `w_valid` 3 cycles after `layer_signal`=1.
  - `w_last` on 0x0A; `layer_done` 1 cycle later.
  - Exactly 2 `fifo_re` pulses.
- Backpressure: toggle `w_ready` 1,0,0,1 during C3 (4 words):
  - `w_data` holds while not ready; 20 weights delivered in order.
  - No extra FIFO reads.
- Empty stall: C5 with FIFO emptied for 10 cycles after word 3:
  - `fifo_re` stays low and `w_valid` low during the stall.
  - Resumes on refill; 120 weights total; `layer_done` once.
- Layer hold and restart: after FC `DONE`, keep `layer_signal`=6 for 20 cycles:
  - No new reads; `layer_done` pulses only once.
  - Switch to 0 then 7: OL stream of 10 weights runs.
- Ignore codes: `layer_signal`=2 and 4 for 10 cycles each → `busy`=0, `fifo_re`=0.
- Reset mid-C5 after 7 weights: all outputs 0 next cycle; state `IDLE`; new C1 run delivers correctly from a fresh FIFO.
